// File: rtl/multicyc_cu_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, ALU ops, mux selects, states, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional build macro MULTICYC_ILLEGAL_TRAP_EN adds the TRAP state.
package multicyc_cu_pkg;

    // Instruction opcodes (Instr[31:26])
    localparam logic [5:0] OP_RR    = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation encodings
    localparam logic [3:0] ALUOP_ADD  = 4'b0010;
    localparam logic [3:0] ALUOP_ADDU = 4'b0011;
    localparam logic [3:0] ALUOP_SUB  = 4'b0110;
    localparam logic [3:0] ALUOP_RR   = 4'b1111;

    // Datapath select values
    localparam logic       WR_RT        = 1'b0;
    localparam logic       WR_RD        = 1'b1;
    localparam logic       ALU_DATA     = 1'b0;
    localparam logic       MEM_DATA     = 1'b1;
    localparam logic       IORD_PC      = 1'b0;
    localparam logic       IORD_ALUOUT  = 1'b1;
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_REG     = 1'b1;
    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
`ifdef MULTICYC_ILLEGAL_TRAP_EN
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
`else
        S_JUMP   = 4'd11
`endif
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_we;
        logic       reg_we;
        logic       wreg_dst_sel;
        logic       wrbck_data_sel;
        logic       alu_srca_sel;
        logic [1:0] alu_srcb_sel;
        logic [1:0] pc_src_sel;
        logic       is_beq;
        logic [3:0] aluop;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RR, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicyc_cu_outdec.sv
// Combinational state/opcode to control-word decode for the multicycle control unit.
// Latency: 0 cycles (pure combinational).
// Backpressure: fetch enables and store completion follow the qualified memory-ready input.
module multicyc_cu_outdec
    import multicyc_cu_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ok,
    output ctrl_t      ctrl
);

    // Decode the control word; everything not named for a state stays 0, ALU defaults to ADD
    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ctrl.iord         = IORD_PC;
                ctrl.mem_rd       = 1'b1;
                ctrl.alu_srca_sel = SRCA_PC;
                ctrl.alu_srcb_sel = SRCB_FOUR;
                ctrl.pc_src_sel   = PCSRC_ALU;
                ctrl.ir_we        = mem_ok;
                ctrl.pc_we        = mem_ok;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here
                ctrl.alu_srca_sel = SRCA_PC;
                ctrl.alu_srcb_sel = SRCB_IMM_SH2;
`ifndef MULTICYC_ILLEGAL_TRAP_EN
                // Unknown opcodes retire here as a NOP
                ctrl.instr_done   = !op_is_legal(opcode);
`endif
            end
            S_MEMADR: begin
                ctrl.alu_srca_sel = SRCA_REG;
                ctrl.alu_srcb_sel = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.iord   = IORD_ALUOUT;
                ctrl.mem_rd = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_we         = 1'b1;
                ctrl.wreg_dst_sel   = WR_RT;
                ctrl.wrbck_data_sel = MEM_DATA;
                ctrl.instr_done     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = IORD_ALUOUT;
                ctrl.mem_we     = 1'b1;
                ctrl.instr_done = mem_ok;
            end
            S_EXEC_R: begin
                ctrl.alu_srca_sel = SRCA_REG;
                ctrl.alu_srcb_sel = SRCB_REG;
                ctrl.aluop        = ALUOP_RR;
            end
            S_RWB: begin
                ctrl.reg_we         = 1'b1;
                ctrl.wreg_dst_sel   = WR_RD;
                ctrl.wrbck_data_sel = ALU_DATA;
                ctrl.instr_done     = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_srca_sel = SRCA_REG;
                ctrl.alu_srcb_sel = SRCB_REG;
                ctrl.aluop        = ALUOP_SUB;
                ctrl.is_beq       = 1'b1;
                ctrl.pc_src_sel   = PCSRC_ALUOUT;
                ctrl.instr_done   = 1'b1;
            end
            S_IEXEC: begin
                ctrl.alu_srca_sel = SRCA_REG;
                ctrl.alu_srcb_sel = SRCB_IMM;
                ctrl.aluop        = (opcode == OP_ADDIU) ? ALUOP_ADDU : ALUOP_ADD;
            end
            S_IWB: begin
                ctrl.reg_we         = 1'b1;
                ctrl.wreg_dst_sel   = WR_RT;
                ctrl.wrbck_data_sel = ALU_DATA;
                ctrl.instr_done     = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_we      = 1'b1;
                ctrl.pc_src_sel = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`ifdef MULTICYC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicyc_cu.sv
// Moore control unit for the multicycle MIPS datapath (shared instruction/data memory port).
// Latency: 3 to 5 cycles per instruction plus one per memory wait cycle; MULTICYC_ILLEGAL_TRAP_EN enables TRAP.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low (ignored when MEM_HANDSHAKE = 0).
module multicyc_cu
    import multicyc_cu_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       reg_we,
    output logic       wreg_dst_sel,
    output logic       wrbck_data_sel,
    output logic       alu_srca_sel,
    output logic [1:0] alu_srcb_sel,
    output logic [1:0] pc_src_sel,
    output logic       is_beq,
    output logic [3:0] aluop,
    output logic       instr_done,
    output logic       illegal
);

    state_t state;
    ctrl_t  ctrl;
    logic   mem_ok;

    assign mem_ok = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    // State register and next-state sequencing; unknown encodings fall back to FETCH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= mem_ok ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:      state <= S_MEMADR;
                        OP_RR:             state <= S_EXEC_R;
                        OP_BEQ:            state <= S_BRANCH;
                        OP_J:              state <= S_JUMP;
                        OP_ADDI, OP_ADDIU: state <= S_IEXEC;
`ifdef MULTICYC_ILLEGAL_TRAP_EN
                        default:           state <= S_TRAP;
`else
                        default:           state <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= mem_ok ? S_MEMWB : S_MEMRD;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  state <= mem_ok ? S_FETCH : S_MEMWR;
                S_EXEC_R: state <= S_RWB;
                S_RWB:    state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_IEXEC:  state <= S_IWB;
                S_IWB:    state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
`ifdef MULTICYC_ILLEGAL_TRAP_EN
                S_TRAP:   state <= S_TRAP;
`endif
                default:  state <= S_FETCH;
            endcase
        end
    end

    multicyc_cu_outdec u_outdec (
        .state  (state),
        .opcode (opcode),
        .mem_ok (mem_ok),
        .ctrl   (ctrl)
    );

    // Strobes are squashed while reset is held so an abandoned instruction cannot write anything
    assign pc_we          = ctrl.pc_we      & rst_n;
    assign ir_we          = ctrl.ir_we      & rst_n;
    assign mem_rd         = ctrl.mem_rd     & rst_n;
    assign mem_we         = ctrl.mem_we     & rst_n;
    assign reg_we         = ctrl.reg_we     & rst_n;
    assign instr_done     = ctrl.instr_done & rst_n;
    assign illegal        = ctrl.illegal    & rst_n;
    assign iord           = ctrl.iord;
    assign wreg_dst_sel   = ctrl.wreg_dst_sel;
    assign wrbck_data_sel = ctrl.wrbck_data_sel;
    assign alu_srca_sel   = ctrl.alu_srca_sel;
    assign alu_srcb_sel   = ctrl.alu_srcb_sel;
    assign pc_src_sel     = ctrl.pc_src_sel;
    assign is_beq         = ctrl.is_beq;
    assign aluop          = ctrl.aluop;

endmodule

// File: tb/tb_multicyc_cu.sv
// Directed self-checking bench for multicyc_cu: per-cycle control word against hand-written vectors.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Honours MULTICYC_ILLEGAL_TRAP_EN for the illegal-opcode scenario.
module tb_multicyc_cu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_we, ir_we, iord, mem_rd, mem_we, reg_we;
    logic       wreg_dst_sel, wrbck_data_sel, alu_srca_sel;
    logic [1:0] alu_srcb_sel, pc_src_sel;
    logic       is_beq;
    logic [3:0] aluop;
    logic       instr_done, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicyc_cu #(.MEM_HANDSHAKE(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode         (opcode),
        .mem_ready      (mem_ready),
        .pc_we          (pc_we),
        .ir_we          (ir_we),
        .iord           (iord),
        .mem_rd         (mem_rd),
        .mem_we         (mem_we),
        .reg_we         (reg_we),
        .wreg_dst_sel   (wreg_dst_sel),
        .wrbck_data_sel (wrbck_data_sel),
        .alu_srca_sel   (alu_srca_sel),
        .alu_srcb_sel   (alu_srcb_sel),
        .pc_src_sel     (pc_src_sel),
        .is_beq         (is_beq),
        .aluop          (aluop),
        .instr_done     (instr_done),
        .illegal        (illegal)
    );

    // Observed word: {pc_we,ir_we,iord,mem_rd,mem_we,reg_we,wdst,wbsel,srca,srcb[2],pcsrc[2],is_beq,aluop[4],done,illegal}
    logic [19:0] obs;
    assign obs = {pc_we, ir_we, iord, mem_rd, mem_we, reg_we, wreg_dst_sel, wrbck_data_sel,
                  alu_srca_sel, alu_srcb_sel, pc_src_sel, is_beq, aluop, instr_done, illegal};

    localparam logic [3:0] A_ADD  = 4'b0010;
    localparam logic [3:0] A_ADDU = 4'b0011;
    localparam logic [3:0] A_SUB  = 4'b0110;
    localparam logic [3:0] A_RR   = 4'b1111;

    //                                 pcw   irw   iord  mrd   mwe   rwe   wdst  wbs   srca  srcb  pcs   beq   aluop  done  ill
    localparam logic [19:0] V_RST     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_FETCH   = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_FETCH_W = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_DEC     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_DEC_NOP = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, A_ADD,  1'b1, 1'b0};
    localparam logic [19:0] V_MEMADR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_MEMRD   = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_MEMRD_R = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_MEMWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b1, 1'b0};
    localparam logic [19:0] V_MEMWR_W = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_MEMWR   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b1, 1'b0};
    localparam logic [19:0] V_EXR     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, A_RR,   1'b0, 1'b0};
    localparam logic [19:0] V_RWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b1, 1'b0};
    localparam logic [19:0] V_BR      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, A_SUB,  1'b1, 1'b0};
    localparam logic [19:0] V_IEX_U   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, A_ADDU, 1'b0, 1'b0};
    localparam logic [19:0] V_IEX     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};
    localparam logic [19:0] V_IWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b1, 1'b0};
    localparam logic [19:0] V_JMP     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, A_ADD,  1'b1, 1'b0};
    localparam logic [19:0] V_TRAP    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b0, 1'b1};
    localparam logic [19:0] V_TRAP_R  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, A_ADD,  1'b0, 1'b0};

    // Two reset cycles with mem_ready high, then a J instruction straight out of reset
    task automatic test_reset();
        logic [19:0] ev [0:2];
        ev = '{V_FETCH, V_DEC, V_JMP};
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (obs !== V_RST) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, V_RST);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL reset_release_j cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
    endtask

    // LW with no wait states: five cycles, one writeback and one done pulse
    task automatic test_lw();
        logic [19:0] ev [0:4];
        int done_cnt = 0;
        ev = '{V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            opcode = 6'b100011; mem_ready = 1'b1;
            #1;
            if (instr_done === 1'b1) done_cnt++;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL lw_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    // SW with three wait cycles in MEMWR: seven cycles, four mem_we cycles, no reg_we
    task automatic test_sw_wait();
        logic [19:0] ev [0:6];
        logic        mr [0:6];
        int we_cnt = 0;
        int rwe_cnt = 0;
        ev = '{V_FETCH, V_DEC, V_MEMADR, V_MEMWR_W, V_MEMWR_W, V_MEMWR_W, V_MEMWR};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            opcode = 6'b101011; mem_ready = mr[i];
            #1;
            if (mem_we === 1'b1) we_cnt++;
            if (reg_we === 1'b1) rwe_cnt++;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL sw_wait cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        n_checks++;
        if (we_cnt !== 4 || rwe_cnt !== 0) begin
            n_fail++;
            $display("FAIL sw_strobe_counts: got mem_we=%0d reg_we=%0d expected 4 and 0", we_cnt, rwe_cnt);
        end
    endtask

    // RR, BEQ, J, ADDIU, ADDI back to back: 4,3,3,4,4 cycles
    task automatic test_back_to_back();
        logic [19:0] ev [0:17];
        logic [5:0]  op [0:17];
        int done_cnt = 0;
        ev = '{V_FETCH, V_DEC, V_EXR, V_RWB,
               V_FETCH, V_DEC, V_BR,
               V_FETCH, V_DEC, V_JMP,
               V_FETCH, V_DEC, V_IEX_U, V_IWB,
               V_FETCH, V_DEC, V_IEX, V_IWB};
        op = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
               6'b000100, 6'b000100, 6'b000100,
               6'b000010, 6'b000010, 6'b000010,
               6'b001001, 6'b001001, 6'b001001, 6'b001001,
               6'b001000, 6'b001000, 6'b001000, 6'b001000};
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            opcode = op[i]; mem_ready = 1'b1;
            #1;
            if (instr_done === 1'b1) done_cnt++;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        n_checks++;
        if (done_cnt !== 5) begin
            n_fail++;
            $display("FAIL back_to_back_done_count: got %0d expected 5", done_cnt);
        end
    endtask

    // Opcode 111111: trap and hold until reset, or retire as a 2-cycle NOP
    task automatic test_illegal();
`ifdef MULTICYC_ILLEGAL_TRAP_EN
        logic [19:0] ev [0:5];
        ev = '{V_FETCH, V_DEC, V_TRAP, V_TRAP, V_TRAP, V_TRAP};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            opcode = 6'b111111; mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL illegal_trap cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== V_TRAP_R) begin
            n_fail++;
            $display("FAIL illegal_trap_reset: got %h expected %h", obs, V_TRAP_R);
        end
`else
        logic [19:0] ev [0:2];
        ev = '{V_FETCH, V_DEC_NOP, V_FETCH};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode = (i < 2) ? 6'b111111 : 6'b000010; mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL illegal_nop cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        // finish the J started in the last FETCH so the next task begins in FETCH
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
        end
        n_checks++;
        if (obs !== V_JMP) begin
            n_fail++;
            $display("FAIL illegal_nop_followon: got %h expected %h", obs, V_JMP);
        end
`endif
    endtask

    // Reset while LW stalls in MEMRD: restart at FETCH with no writeback
    task automatic test_reset_mid();
        logic [19:0] ev [0:7];
        logic        mr [0:7];
        logic        rs [0:7];
        int rwe_cnt = 0;
        ev = '{V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMRD_R, V_FETCH_W, V_FETCH, V_DEC};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        rs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            opcode = 6'b100011; mem_ready = mr[i]; rst_n = rs[i];
            #1;
            if (i >= 4 && reg_we === 1'b1) rwe_cnt++;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", i, obs, ev[i]);
            end
        end
        n_checks++;
        if (rwe_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_writeback: got %0d reg_we cycles expected 0", rwe_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 6'b000000;
        mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_sw_wait();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
